// File: rtl/alu_cmd_ctrl.sv
// UART command controller: collects a num1/oper/num2 frame, drives the ALU operands,
// and answers with a status byte followed by the result byte.
module alu_cmd_ctrl #(
    parameter int TIMEOUT_CYC = 1_000_000,
    parameter int CNT_W       = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_valid,
    input  logic [7:0] rx_data,
    input  logic       tx_busy,
    output logic       tx_start,
    output logic [7:0] tx_data,
    output logic [7:0] alu_num1,
    output logic [7:0] alu_num2,
    output logic [3:0] alu_oper,
    input  logic [7:0] alu_result,
    output logic       busy,
    output logic       err
);

    typedef enum logic [2:0] {
        IDLE, GET_OP, GET_NUM2, EXEC, TX_STAT, GAP_STAT, TX_RES, GAP_RES
    } state_t;

    localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT_CYC);

    state_t           state_q, state_d;
    logic [7:0]       num1_q, num1_d;
    logic [7:0]       num2_q, num2_d;
    logic [3:0]       oper_q, oper_d;
    logic [7:0]       oper_raw_q, oper_raw_d;
    logic [7:0]       status_q, status_d;
    logic [7:0]       result_q, result_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       exec_status;
    logic             tx_start_c, err_c, busy_c;
    logic [7:0]       tx_data_c;

    // 0x00 ok, 0x01 unknown opcode byte, 0x02 divide/remainder by zero
    function automatic logic [7:0] calc_status(input logic [7:0] oper, input logic [7:0] n2);
        logic [7:0] st;
        case (oper)
            8'h00, 8'h01, 8'h02: st = 8'h00;
            8'h04, 8'h08:        st = (n2 == 8'h00) ? 8'h02 : 8'h00;
            default:             st = 8'h01;
        endcase
        return st;
    endfunction

    always_comb begin
        state_d     = state_q;
        num1_d      = num1_q;
        num2_d      = num2_q;
        oper_d      = oper_q;
        oper_raw_d  = oper_raw_q;
        status_d    = status_q;
        result_d    = result_q;
        cnt_d       = cnt_q;
        tx_start_c  = 1'b0;
        tx_data_c   = 8'h00;
        err_c       = 1'b0;
        busy_c      = 1'b0;
        exec_status = calc_status(oper_raw_q, num2_q);

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (rx_valid) begin
                    num1_d  = rx_data;
                    state_d = GET_OP;
                end
            end
            GET_OP: begin
                // Expiry is tested before rx_valid so a late byte is dropped
                if (cnt_q == TIMEOUT_VAL) begin
                    err_c   = 1'b1;
                    cnt_d   = '0;
                    state_d = IDLE;
                end else if (rx_valid) begin
                    oper_d     = rx_data[3:0];
                    oper_raw_d = rx_data;
                    cnt_d      = '0;
                    state_d    = GET_NUM2;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            GET_NUM2: begin
                if (cnt_q == TIMEOUT_VAL) begin
                    err_c   = 1'b1;
                    cnt_d   = '0;
                    state_d = IDLE;
                end else if (rx_valid) begin
                    num2_d  = rx_data;
                    cnt_d   = '0;
                    state_d = EXEC;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            EXEC: begin
                busy_c   = 1'b1;
                status_d = exec_status;
                result_d = (exec_status == 8'h00) ? alu_result : 8'h00;
                err_c    = (exec_status != 8'h00);
                state_d  = TX_STAT;
            end
            TX_STAT: begin
                busy_c    = 1'b1;
                tx_data_c = status_q;
                if (!tx_busy) begin
                    tx_start_c = 1'b1;
                    state_d    = GAP_STAT;
                end
            end
            GAP_STAT: begin
                busy_c  = 1'b1;
                state_d = TX_RES;
            end
            TX_RES: begin
                busy_c    = 1'b1;
                tx_data_c = result_q;
                if (!tx_busy) begin
                    tx_start_c = 1'b1;
                    state_d    = GAP_RES;
                end
            end
            GAP_RES: begin
                busy_c  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Outputs decode the current state, so hold them quiet while reset is applied
        if (rst) begin
            tx_start_c = 1'b0;
            tx_data_c  = 8'h00;
            err_c      = 1'b0;
            busy_c     = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            num1_q     <= 8'h00;
            num2_q     <= 8'h00;
            oper_q     <= 4'h0;
            oper_raw_q <= 8'h00;
            status_q   <= 8'h00;
            result_q   <= 8'h00;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            num1_q     <= num1_d;
            num2_q     <= num2_d;
            oper_q     <= oper_d;
            oper_raw_q <= oper_raw_d;
            status_q   <= status_d;
            result_q   <= result_d;
            cnt_q      <= cnt_d;
        end
    end

    assign tx_start = tx_start_c;
    assign tx_data  = tx_data_c;
    assign err      = err_c;
    assign busy     = busy_c;
    assign alu_num1 = num1_q;
    assign alu_num2 = num2_q;
    assign alu_oper = oper_q;

endmodule
